// File: rtl/regfile_wr_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_sched_pkg
// Description : Shared constants and helpers for the register-file write
//               scheduler: instruction classes, OPCODE field positions,
//               FSM state encoding and an OPCODE field decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_wr_sched_pkg;

   // Instruction classes from I_Decode that need special handling
   localparam logic [3:0] CLS_BASE = 4'd1;   // Rn <= ALU_RES
   localparam logic [3:0] CLS_DUAL = 4'd2;   // Rd <= ALU_RES then Rn <= ADDR_RES
   localparam logic [3:0] CLS_LDST = 4'd8;   // load / store
   localparam logic [3:0] CLS_NOP  = 4'd9;   // no write
   localparam logic [3:0] CLS_RM   = 4'd10;  // Rm <= ALU_RES

   // OPCODE field positions
   localparam int W_BIT  = 21;
   localparam int L_BIT  = 20;
   localparam int RN_LSB = 16;
   localparam int RD_LSB = 12;
   localparam int RM_LSB = 0;

   // Register index of the program counter
   localparam logic [3:0] PC_IDX = 4'd15;

   // Scheduler state encoding
   localparam int         ST_W       = 2;
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_MEMWAIT = 2'd1;
   localparam logic [1:0] ST_WB2     = 2'd2;

   typedef struct packed {
      logic       w;
      logic       l;
      logic [3:0] rn;
      logic [3:0] rd;
      logic [3:0] rm;
   } op_fields_t;

   function automatic op_fields_t decode_fields(input logic [31:0] op);
      op_fields_t f;
      f.w  = op[W_BIT];
      f.l  = op[L_BIT];
      f.rn = op[RN_LSB +: 4];
      f.rd = op[RD_LSB +: 4];
      f.rm = op[RM_LSB +: 4];
      return f;
   endfunction

endpackage : regfile_wr_sched_pkg
`default_nettype wire

// File: rtl/regfile_wr_sched_timeout.sv
`default_nettype none
// ============================================================================
// Module      : wr_timeout_cnt
// Description : Clear/enable/expire counter guarding the wait for load data.
//               expire is combinational and fires on the MAX-th enabled
//               cycle since the last clear; the counter then wraps to 0.
// Ports       : clk, rst   - clock, asynchronous active-high reset
//               clr        - synchronous clear (has priority over en)
//               en         - count this cycle
//               expire     - en is set and this is the MAX-th counted cycle
// Revision    : 1.0 - initial release
// ============================================================================
module wr_timeout_cnt #(
   parameter int MAX = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int CW = $clog2(MAX + 1);
   localparam logic [CW-1:0] c_last = CW'(MAX - 1);

   logic [CW-1:0] r_cnt;

   assign expire = en && (r_cnt == c_last);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= expire ? '0 : r_cnt + CW'(1);
      end
   end

endmodule : wr_timeout_cnt
`default_nettype wire

// File: rtl/regfile_wr_sched.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_sched
// Description : Owns the single register-file write port and sequences every
//               EXE-stage instruction onto it. Produces the write-cycle count
//               (gcnt), the destination/data pair and a PC load strobe; holds
//               EXE off while waiting for load data or issuing the second write
//               of a two-write instruction.
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               in_valid/in_ready - EXE handshake (ready only in IDLE)
//               dec, opcode       - instruction class and instruction word
//               alu_res, addr_res - primary result, updated base
//               mem_rdy/mem_rdata - load data return
//               rf_we/rf_waddr/rf_wdata - registered write port
//               pc_load           - registered, rf_we to r15
//               gcnt              - 0 first write, 1 second write
//               abort             - one-cycle pulse on load-data timeout
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wr_sched
   import regfile_wr_sched_pkg::*;
#(
   parameter int DW          = 32,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [3:0]    dec,
   input  logic [31:0]   opcode,
   input  logic [DW-1:0] alu_res,
   input  logic [DW-1:0] addr_res,
   input  logic          mem_rdy,
   input  logic [DW-1:0] mem_rdata,
   output logic          rf_we,
   output logic [3:0]    rf_waddr,
   output logic [DW-1:0] rf_wdata,
   output logic          pc_load,
   output logic          gcnt,
   output logic          abort
);

   logic [ST_W-1:0] r_state;
   logic [ST_W-1:0] w_state_nxt;

   // Operands captured at acceptance for the deferred writes
   logic            r_cap_w;
   logic [3:0]      r_cap_rn;
   logic [3:0]      r_cap_rd;
   logic [DW-1:0]   r_cap_addr;

   logic            r_we;
   logic [3:0]      r_waddr;
   logic [DW-1:0]   r_wdata;
   logic            r_pc_load;
   logic            r_gcnt;
   logic            r_abort;

   logic            w_we_nxt;
   logic [3:0]      w_waddr_nxt;
   logic [DW-1:0]   w_wdata_nxt;
   logic            w_gcnt_nxt;

   logic            w_accept;
   logic            w_expire;
   logic            w_tmo_clr;
   logic            w_tmo_en;
   op_fields_t      w_f;

   // Only the register/flag fields of the instruction word matter here
   logic            w_unused_opcode;
   assign w_unused_opcode = ^{opcode[31:22], opcode[11:4]};

   assign w_f      = decode_fields(opcode);
   assign in_ready = (r_state == ST_IDLE);
   assign w_accept = in_valid && in_ready;

   // The counter only runs while waiting; a returned beat stops it
   assign w_tmo_clr = (r_state != ST_MEMWAIT);
   assign w_tmo_en  = (r_state == ST_MEMWAIT) && !mem_rdy;

   wr_timeout_cnt #(
      .MAX (MEM_TIMEOUT)
   ) u_tmo (
      .clk    (clk),
      .rst    (rst),
      .clr    (w_tmo_clr),
      .en     (w_tmo_en),
      .expire (w_expire)
   );

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (dec == CLS_DUAL) begin
                  w_state_nxt = ST_WB2;
               end else if (dec == CLS_LDST && w_f.l) begin
                  w_state_nxt = ST_MEMWAIT;
               end
            end
         end
         ST_MEMWAIT: begin
            if (mem_rdy) begin
               // Base write-back is dropped when it targets the load
               // destination: the loaded data wins.
               w_state_nxt = (r_cap_w && (r_cap_rn != r_cap_rd)) ? ST_WB2 : ST_IDLE;
            end else if (w_expire) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_WB2:  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Write-port selection (registered below)
   // ------------------------------------------------------------------
   always_comb begin
      w_we_nxt    = 1'b0;
      w_waddr_nxt = r_waddr;
      w_wdata_nxt = r_wdata;
      w_gcnt_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               case (dec)
                  CLS_BASE: begin
                     w_we_nxt    = 1'b1;
                     w_waddr_nxt = w_f.rn;
                     w_wdata_nxt = alu_res;
                  end
                  CLS_DUAL, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd11: begin
                     w_we_nxt    = 1'b1;
                     w_waddr_nxt = w_f.rd;
                     w_wdata_nxt = alu_res;
                  end
                  CLS_RM: begin
                     w_we_nxt    = 1'b1;
                     w_waddr_nxt = w_f.rm;
                     w_wdata_nxt = alu_res;
                  end
                  CLS_LDST: begin
                     // Store with write-back updates the base immediately;
                     // loads defer everything until data returns.
                     if (!w_f.l && w_f.w) begin
                        w_we_nxt    = 1'b1;
                        w_waddr_nxt = w_f.rn;
                        w_wdata_nxt = addr_res;
                     end
                  end
                  default: ;
               endcase
            end
         end
         ST_MEMWAIT: begin
            if (mem_rdy) begin
               w_we_nxt    = 1'b1;
               w_waddr_nxt = r_cap_rd;
               w_wdata_nxt = mem_rdata;
            end
         end
         ST_WB2: begin
            w_we_nxt    = 1'b1;
            w_waddr_nxt = r_cap_rn;
            w_wdata_nxt = r_cap_addr;
            w_gcnt_nxt  = 1'b1;
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // Output and capture registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_we       <= 1'b0;
         r_waddr    <= '0;
         r_wdata    <= '0;
         r_pc_load  <= 1'b0;
         r_gcnt     <= 1'b0;
         r_abort    <= 1'b0;
         r_cap_w    <= 1'b0;
         r_cap_rn   <= '0;
         r_cap_rd   <= '0;
         r_cap_addr <= '0;
      end else begin
         r_we      <= w_we_nxt;
         r_waddr   <= w_waddr_nxt;
         r_wdata   <= w_wdata_nxt;
         r_pc_load <= w_we_nxt && (w_waddr_nxt == PC_IDX);
         r_gcnt    <= w_gcnt_nxt;
         r_abort   <= w_expire;
         if (w_accept) begin
            r_cap_w    <= w_f.w;
            r_cap_rn   <= w_f.rn;
            r_cap_rd   <= w_f.rd;
            r_cap_addr <= addr_res;
         end
      end
   end

   assign rf_we    = r_we;
   assign rf_waddr = r_waddr;
   assign rf_wdata = r_wdata;
   assign pc_load  = r_pc_load;
   assign gcnt     = r_gcnt;
   assign abort    = r_abort;

endmodule : regfile_wr_sched
`default_nettype wire

// File: tb/tb_regfile_wr_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wr_sched
// Description : Directed self-checking bench for regfile_wr_sched.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wr_sched;

   localparam int DW          = 32;
   localparam int MEM_TIMEOUT = 15;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    dec;
   logic [31:0]   opcode;
   logic [DW-1:0] alu_res;
   logic [DW-1:0] addr_res;
   logic          mem_rdy;
   logic [DW-1:0] mem_rdata;
   logic          rf_we;
   logic [3:0]    rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic          pc_load;
   logic          gcnt;
   logic          abort;

   int n_cmp = 0;
   int n_bad = 0;

   regfile_wr_sched #(
      .DW          (DW),
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dec       (dec),
      .opcode    (opcode),
      .alu_res   (alu_res),
      .addr_res  (addr_res),
      .mem_rdy   (mem_rdy),
      .mem_rdata (mem_rdata),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .pc_load   (pc_load),
      .gcnt      (gcnt),
      .abort     (abort)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mkop(input logic w, input logic l,
                                        input logic [3:0] rn, input logic [3:0] rd,
                                        input logic [3:0] rm);
      logic [31:0] op;
      op        = 32'h0;
      op[21]    = w;
      op[20]    = l;
      op[19:16] = rn;
      op[15:12] = rd;
      op[3:0]   = rm;
      return op;
   endfunction

   task automatic drive(input logic [3:0] d, input logic [31:0] op,
                        input logic [DW-1:0] a, input logic [DW-1:0] b);
      in_valid = 1'b1;
      dec      = d;
      opcode   = op;
      alu_res  = a;
      addr_res = b;
   endtask

   initial begin
      int  cyc;
      bit  seen_abort;
      bit  seen_we;

      rst       = 1'b1;
      in_valid  = 1'b0;
      dec       = 4'd0;
      opcode    = 32'h0;
      alu_res   = '0;
      addr_res  = '0;
      mem_rdy   = 1'b0;
      mem_rdata = '0;
      tick();
      tick();

      // Reset state
      chk("rst_in_ready", in_ready, 1);
      chk("rst_we",       rf_we,    0);
      chk("rst_waddr",    rf_waddr, 0);
      chk("rst_wdata",    rf_wdata, 0);
      chk("rst_pc_load",  pc_load,  0);
      chk("rst_gcnt",     gcnt,     0);
      chk("rst_abort",    abort,    0);
      rst = 1'b0;
      tick();

      // Single write to Rd
      drive(4'd3, mkop(0, 0, 4'd0, 4'd4, 4'd0), 32'h55, 32'h0);
      tick();
      in_valid = 1'b0;
      chk("d3_we",    rf_we,    1);
      chk("d3_waddr", rf_waddr, 4);
      chk("d3_wdata", rf_wdata, 32'h55);
      chk("d3_gcnt",  gcnt,     0);
      chk("d3_pc",    pc_load,  0);
      tick();
      chk("idle_we",    rf_we,    0);
      chk("idle_waddr", rf_waddr, 4);
      chk("idle_wdata", rf_wdata, 32'h55);

      // Back-to-back single-write classes: Rd, Rn, Rm
      drive(4'd5, mkop(0, 0, 4'd1, 4'd7, 4'd0), 32'h70, 32'h0);
      tick();
      chk("b2b0_we",    rf_we,    1);
      chk("b2b0_waddr", rf_waddr, 7);
      chk("b2b0_rdy",   in_ready, 1);
      drive(4'd1, mkop(0, 0, 4'd9, 4'd3, 4'd0), 32'h91, 32'h0);
      tick();
      chk("b2b1_we",    rf_we,    1);
      chk("b2b1_waddr", rf_waddr, 9);
      chk("b2b1_wdata", rf_wdata, 32'h91);
      drive(4'd10, mkop(0, 0, 4'd5, 4'd6, 4'd2), 32'hA2, 32'h0);
      tick();
      in_valid = 1'b0;
      chk("b2b2_we",    rf_we,    1);
      chk("b2b2_waddr", rf_waddr, 2);
      chk("b2b2_wdata", rf_wdata, 32'hA2);

      // Dual write: R1 <= 0xA then R2 <= 0xB
      drive(4'd2, mkop(0, 0, 4'd2, 4'd1, 4'd0), 32'hA, 32'hB);
      tick();
      in_valid = 1'b0;
      chk("dual1_we",    rf_we,    1);
      chk("dual1_waddr", rf_waddr, 1);
      chk("dual1_wdata", rf_wdata, 32'hA);
      chk("dual1_gcnt",  gcnt,     0);
      chk("dual1_rdy",   in_ready, 0);
      tick();
      chk("dual2_we",    rf_we,    1);
      chk("dual2_waddr", rf_waddr, 2);
      chk("dual2_wdata", rf_wdata, 32'hB);
      chk("dual2_gcnt",  gcnt,     1);
      tick();
      chk("dual3_rdy", in_ready, 1);
      chk("dual3_we",  rf_we,    0);

      // Load with write-back, data after 3 cycles
      drive(4'd8, mkop(1, 1, 4'd5, 4'd3, 4'd0), 32'h0, 32'h100);
      tick();
      in_valid = 1'b0;
      chk("ld_acc_we",  rf_we,    0);
      chk("ld_acc_rdy", in_ready, 0);
      tick();
      chk("ld_w1_we", rf_we, 0);
      tick();
      mem_rdy   = 1'b1;
      mem_rdata = 32'hDEAD;
      tick();
      mem_rdy = 1'b0;
      chk("ld_d_we",    rf_we,    1);
      chk("ld_d_waddr", rf_waddr, 3);
      chk("ld_d_wdata", rf_wdata, 32'hDEAD);
      chk("ld_d_gcnt",  gcnt,     0);
      tick();
      chk("ld_b_we",    rf_we,    1);
      chk("ld_b_waddr", rf_waddr, 5);
      chk("ld_b_wdata", rf_wdata, 32'h100);
      chk("ld_b_gcnt",  gcnt,     1);
      tick();
      chk("ld_end_rdy", in_ready, 1);
      chk("ld_end_we",  rf_we,    0);

      // Load Rd==Rn with W=1; MEM_RDY already high in acceptance cycle
      drive(4'd8, mkop(1, 1, 4'd6, 4'd6, 4'd0), 32'h0, 32'h600);
      mem_rdy   = 1'b1;
      mem_rdata = 32'h66;
      tick();
      in_valid = 1'b0;
      chk("ldeq_acc_we", rf_we, 0);
      tick();
      mem_rdy = 1'b0;
      chk("ldeq_we",    rf_we,    1);
      chk("ldeq_waddr", rf_waddr, 6);
      chk("ldeq_wdata", rf_wdata, 32'h66);
      tick();
      chk("ldeq_end_we",  rf_we,    0);
      chk("ldeq_end_rdy", in_ready, 1);

      // Load timeout: abort after MEM_TIMEOUT waiting cycles, no write
      drive(4'd8, mkop(0, 1, 4'd1, 4'd7, 4'd0), 32'h0, 32'h0);
      tick();
      in_valid   = 1'b0;
      seen_abort = 1'b0;
      seen_we    = 1'b0;
      cyc        = 0;
      for (int i = 1; i <= 20 && !seen_abort; i++) begin
         tick();
         cyc = i;
         if (rf_we) seen_we = 1'b1;
         if (abort) seen_abort = 1'b1;
      end
      chk("tmo_abort", seen_abort, 1);
      chk("tmo_cycle", cyc, MEM_TIMEOUT);
      chk("tmo_no_we", seen_we, 0);
      chk("tmo_rdy",   in_ready, 1);
      tick();
      chk("tmo_pulse", abort, 0);

      // Write to PC
      drive(4'd4, mkop(0, 0, 4'd0, 4'd15, 4'd0), 32'h400, 32'h0);
      tick();
      in_valid = 1'b0;
      chk("pc_we",    rf_we,    1);
      chk("pc_load",  pc_load,  1);
      chk("pc_waddr", rf_waddr, 15);
      tick();
      chk("pc_load_off", pc_load, 0);

      // No-write classes, then store with write-back
      drive(4'd9, mkop(1, 0, 4'd3, 4'd3, 4'd3), 32'h99, 32'h99);
      tick();
      chk("nop_we", rf_we, 0);
      drive(4'd8, mkop(0, 0, 4'd3, 4'd4, 4'd0), 32'h11, 32'h22);
      tick();
      chk("st_now_we", rf_we, 0);
      drive(4'd8, mkop(1, 0, 4'd3, 4'd4, 4'd0), 32'h11, 32'h333);
      tick();
      in_valid = 1'b0;
      chk("stw_we",    rf_we,    1);
      chk("stw_waddr", rf_waddr, 3);
      chk("stw_wdata", rf_wdata, 32'h333);

      // Asynchronous reset in the middle of a load wait
      drive(4'd8, mkop(1, 1, 4'd4, 4'd2, 4'd0), 32'h0, 32'h44);
      tick();
      in_valid = 1'b0;
      tick();
      chk("rstm_pre_rdy", in_ready, 0);
      #2 rst = 1'b1;
      #1;
      chk("rstm_rdy",   in_ready, 1);
      chk("rstm_we",    rf_we,    0);
      chk("rstm_abort", abort,    0);
      @(posedge clk);
      #1 rst = 1'b0;
      mem_rdy   = 1'b1;
      mem_rdata = 32'hBAD;
      seen_we   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (rf_we) seen_we = 1'b1;
      end
      mem_rdy = 1'b0;
      chk("rstm_no_we", seen_we, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_regfile_wr_sched
`default_nettype wire
